// File: rtl/ifetch_queue_2432.sv
// Instruction prefetch queue: issues sequential fetches, buffers PC-tagged 24b instructions
// in a small FIFO and hands them to decode; redirects flush and drain in-flight responses.
module ifetch_queue_2432 #(
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          ADDR_W   = 24,
    parameter int unsigned          INSTR_W  = 24,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rstb,
    input  logic                i_clk_en,
    input  logic                i_redirect,
    input  logic [ADDR_W-1:0]   i_redirect_addr,
    output logic                o_mem_rd,
    output logic [ADDR_W-1:0]   o_mem_addr,
    input  logic                i_mem_valid,
    input  logic [INSTR_W-1:0]  i_mem_data,
    output logic                o_instr_valid,
    input  logic                i_instr_ready,
    output logic [INSTR_W-1:0]  o_instr,
    output logic [ADDR_W-1:0]   o_instr_pc,
    output logic                o_err
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W:0] L_DEPTH = (CNT_W + 1)'(DEPTH);

    localparam logic [1:0] S_RST   = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         r_state, w_state_d;
    logic [ADDR_W-1:0]  r_fetch_pc, w_fetch_pc_d;
    logic [ADDR_W-1:0]  r_resp_pc, w_resp_pc_d;
    logic [CNT_W-1:0]   r_count, w_count_d;
    logic [CNT_W-1:0]   r_outstanding, w_outstanding_d;
    logic [PTR_W-1:0]   r_wptr, w_wptr_d;
    logic [PTR_W-1:0]   r_rptr, w_rptr_d;
    logic               r_err, w_err_d;
    logic [INSTR_W-1:0] r_last_instr;
    logic [ADDR_W-1:0]  r_last_pc;
    logic [ENT_W-1:0]   r_fifo [DEPTH];

    logic               w_redirect;
    logic [CNT_W:0]     w_inflight;
    logic               w_issue;
    logic               w_valid;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic [ENT_W-1:0]   w_head;

    // Redirects are ignored while still coming out of reset.
    assign w_redirect = i_redirect & (r_state != S_RST);

    // FIFO occupancy plus in-flight requests is the credit; a push can never find it full.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_issue    = (r_state == S_RUN) & (w_inflight < L_DEPTH) & ~i_redirect;
    assign w_valid    = (r_state == S_RUN) & (r_count != '0) & ~i_redirect;
    assign w_resp     = i_mem_valid & (r_outstanding != '0);
    assign w_push     = w_resp & (r_state == S_RUN) & ~i_redirect;
    assign w_pop      = w_valid & i_instr_ready;
    assign w_head     = r_fifo[r_rptr];

    always_comb begin
        w_state_d       = r_state;
        w_fetch_pc_d    = r_fetch_pc;
        w_resp_pc_d     = r_resp_pc;
        w_count_d       = r_count;
        w_wptr_d        = r_wptr;
        w_rptr_d        = r_rptr;
        w_err_d         = r_err | (i_mem_valid & (r_outstanding == '0));
        w_outstanding_d = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_resp);

        case (r_state)
            S_RST:   w_state_d = S_RUN;
            S_RUN: begin
                if (w_redirect) begin
                    w_state_d = (w_outstanding_d != '0) ? S_DRAIN : S_RUN;
                end
            end
            S_DRAIN: begin
                if (!w_redirect && (w_outstanding_d == '0)) begin
                    w_state_d = S_RUN;
                end
            end
            default: w_state_d = S_RST;
        endcase

        if (w_redirect) begin
            w_fetch_pc_d = i_redirect_addr;
            w_resp_pc_d  = i_redirect_addr;
            w_count_d    = '0;
            w_wptr_d     = '0;
            w_rptr_d     = '0;
        end else begin
            if (w_issue) begin
                w_fetch_pc_d = r_fetch_pc + ADDR_W'(1);
            end
            if (w_push) begin
                w_resp_pc_d = r_resp_pc + ADDR_W'(1);
                w_wptr_d    = r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rptr_d = r_rptr + PTR_W'(1);
            end
            w_count_d = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state       <= S_RST;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_err         <= 1'b0;
            r_last_instr  <= '0;
            r_last_pc     <= '0;
        end else if (i_clk_en) begin
            r_state       <= w_state_d;
            r_fetch_pc    <= w_fetch_pc_d;
            r_resp_pc     <= w_resp_pc_d;
            r_count       <= w_count_d;
            r_outstanding <= w_outstanding_d;
            r_wptr        <= w_wptr_d;
            r_rptr        <= w_rptr_d;
            r_err         <= w_err_d;
            // Remember what was last shown so the outputs hold once the head is gone.
            if (w_valid) begin
                r_last_instr <= w_head[INSTR_W-1:0];
                r_last_pc    <= w_head[ENT_W-1:INSTR_W];
            end
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && w_push) begin
            r_fifo[r_wptr] <= {r_resp_pc, i_mem_data};
        end
    end

    assign o_mem_rd      = w_issue;
    assign o_mem_addr    = r_fetch_pc;
    assign o_instr_valid = w_valid;
    assign o_instr       = w_valid ? w_head[INSTR_W-1:0]     : r_last_instr;
    assign o_instr_pc    = w_valid ? w_head[ENT_W-1:INSTR_W] : r_last_pc;
    assign o_err         = r_err;

endmodule

// File: tb/tb_ifetch_queue_2432.sv
// Bench for ifetch_queue_2432: queue-based reference model checked every cycle, a latency-
// configurable ROM (ROM[a] = a ^ 5A5A5A) and directed scenarios with literal expectations.
module tb_ifetch_queue_2432;
    localparam int          DEPTH   = 4;
    localparam logic [23:0] ROM_KEY = 24'h5A5A5A;
    localparam int          M_RST   = 0;
    localparam int          M_RUN   = 1;
    localparam int          M_DRAIN = 2;

    logic        clk;
    logic        rstb;
    logic        clk_en;
    logic        redirect;
    logic [23:0] redirect_addr;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic        mem_valid;
    logic [23:0] mem_data;
    logic        instr_valid;
    logic        ready;
    logic [23:0] instr;
    logic [23:0] instr_pc;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          m_state;
    logic [23:0] m_fetch;
    logic [23:0] m_resp;
    int          m_out;
    bit          m_err;
    logic [47:0] m_q[$];

    // memory environment and observation logs
    int          mem_lat = 1;
    int          ecount  = 0;
    bit          spurious = 0;
    bit          rst_req  = 1;
    logic [23:0] mq_addr[$];
    int          mq_due[$];
    logic [23:0] dlog_pc[$];
    logic [23:0] dlog_d[$];
    logic [23:0] iss_log[$];

    ifetch_queue_2432 #(
        .DEPTH    (DEPTH),
        .ADDR_W   (24),
        .INSTR_W  (24),
        .RESET_PC (24'h0)
    ) u_dut (
        .i_clk           (clk),
        .i_rstb          (rstb),
        .i_clk_en        (clk_en),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr),
        .o_mem_rd        (mem_rd),
        .o_mem_addr      (mem_addr),
        .i_mem_valid     (mem_valid),
        .i_mem_data      (mem_data),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (ready),
        .o_instr         (instr),
        .o_instr_pc      (instr_pc),
        .o_err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_RST;
        m_fetch = 24'h0;
        m_resp  = 24'h0;
        m_out   = 0;
        m_err   = 0;
        m_q.delete();
    endtask

    // One clock: drive inputs at negedge, compare, then advance model and memory.
    task automatic step(input bit en, input bit redir, input logic [23:0] raddr, input bit rdy);
        bit exp_rd;
        bit exp_valid;
        bit rom_hit;
        bit resp;
        int cnt;
        @(negedge clk);
        rstb          = !rst_req;
        clk_en        = en;
        redirect      = redir;
        redirect_addr = raddr;
        ready         = rdy;
        if (!rstb) begin
            model_reset();
            mq_addr.delete();
            mq_due.delete();
        end
        rom_hit = (mq_due.size() > 0) && (mq_due[0] <= ecount);
        if (spurious) begin
            mem_valid = 1'b1;
            mem_data  = 24'hABCDEF;
        end else if (rom_hit) begin
            mem_valid = 1'b1;
            mem_data  = mq_addr[0] ^ ROM_KEY;
        end else begin
            mem_valid = 1'b0;
            mem_data  = 24'h0;
        end
        #1;
        if (!rstb) begin
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_mem_addr", mem_addr, 24'h0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_instr", instr, 24'h0);
            chk("rst_instr_pc", instr_pc, 24'h0);
            chk("rst_err", err, 0);
        end else begin
            cnt       = m_q.size();
            exp_rd    = (m_state == M_RUN) && (cnt + m_out < DEPTH) && !redir;
            exp_valid = (m_state == M_RUN) && (cnt != 0) && !redir;
            chk("mem_rd", mem_rd, exp_rd);
            chk("mem_addr", mem_addr, m_fetch);
            chk("instr_valid", instr_valid, exp_valid);
            chk("err", err, m_err);
            if (exp_valid) begin
                chk("instr", instr, m_q[0][23:0]);
                chk("instr_pc", instr_pc, m_q[0][47:24]);
            end
            if (en) begin
                if (instr_valid && rdy) begin
                    dlog_pc.push_back(instr_pc);
                    dlog_d.push_back(instr);
                end
                if (spurious) begin
                    spurious = 0;
                end else if (rom_hit) begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
                if (mem_rd) begin
                    iss_log.push_back(mem_addr);
                    mq_addr.push_back(mem_addr);
                    mq_due.push_back(ecount + mem_lat);
                end
                ecount++;

                resp = mem_valid && (m_out > 0);
                if (mem_valid && m_out == 0) m_err = 1;
                if (m_state == M_RST) begin
                    m_state = M_RUN;
                end else if (redir) begin
                    m_q.delete();
                    m_fetch = raddr;
                    m_resp  = raddr;
                    if (resp) m_out--;
                    if (m_state == M_RUN) m_state = (m_out > 0) ? M_DRAIN : M_RUN;
                end else if (m_state == M_RUN) begin
                    if (exp_valid && rdy) void'(m_q.pop_front());
                    if (exp_rd) begin
                        m_fetch++;
                        m_out++;
                    end
                    if (resp) begin
                        m_q.push_back({m_resp, mem_data});
                        m_resp++;
                        m_out--;
                    end
                end else begin
                    if (resp) m_out--;
                    if (m_out == 0) m_state = M_RUN;
                end
            end
        end
    endtask

    task automatic clear_logs();
        dlog_pc.delete();
        dlog_d.delete();
        iss_log.delete();
    endtask

    task automatic reset_dut();
        rst_req = 1;
        step(1'b0, 1'b0, 24'h0, 1'b0);
        step(1'b0, 1'b0, 24'h0, 1'b0);
        rst_req = 0;
        clear_logs();
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'h0, rdy);
    endtask

    task automatic chk_delivery(input string name, input int idx, input logic [23:0] pc);
        chk({name, "_present"}, (dlog_pc.size() > idx), 1);
        if (dlog_pc.size() > idx) begin
            chk({name, "_pc"}, dlog_pc[idx], pc);
            chk({name, "_data"}, dlog_d[idx], pc ^ ROM_KEY);
        end
    endtask

    initial begin
        rstb = 1'b0; clk_en = 1'b0; redirect = 1'b0; redirect_addr = 24'h0;
        mem_valid = 1'b0; mem_data = 24'h0; ready = 1'b0;
        model_reset();

        // 1: streaming with a 1-cycle ROM
        mem_lat = 1;
        reset_dut();
        run(12, 1'b1);
        chk("t1_count", dlog_pc.size(), 9);
        for (int i = 0; i < dlog_pc.size(); i++) chk_delivery("t1", i, 24'(i));

        // 2: stalled core fills exactly DEPTH entries, then drains in order
        reset_dut();
        run(10, 1'b0);
        chk("t2_issues", iss_log.size(), 4);
        for (int i = 0; i < iss_log.size(); i++) chk("t2_issue_addr", iss_log[i], 24'(i));
        run(8, 1'b1);
        for (int i = 0; i < 5; i++) chk_delivery("t2", i, 24'(i));

        // 3: 3-cycle ROM, redirect with two requests in flight
        mem_lat = 3;
        reset_dut();
        run(3, 1'b1);
        clear_logs();
        step(1'b1, 1'b1, 24'h000100, 1'b1);
        run(12, 1'b1);
        chk("t3_any_issue", (iss_log.size() > 0), 1);
        if (iss_log.size() > 0) chk("t3_first_issue", iss_log[0], 24'h000100);
        chk("t3_first_pc_lit", (dlog_pc.size() > 0) ? dlog_pc[0] : 24'hxxxxxx, 24'h000100);
        chk("t3_first_data_lit", (dlog_d.size() > 0) ? dlog_d[0] : 24'hxxxxxx, 24'h5A5B5A);

        // 4: PC wrap-around after redirect
        mem_lat = 1;
        reset_dut();
        run(3, 1'b1);
        clear_logs();
        step(1'b1, 1'b1, 24'hFFFFFE, 1'b1);
        run(10, 1'b1);
        chk("t4_pc0", (dlog_pc.size() > 2) ? dlog_pc[0] : 24'hxxxxxx, 24'hFFFFFE);
        chk("t4_d0", (dlog_d.size() > 2) ? dlog_d[0] : 24'hxxxxxx, 24'hA5A5A4);
        chk("t4_pc1", (dlog_pc.size() > 2) ? dlog_pc[1] : 24'hxxxxxx, 24'hFFFFFF);
        chk("t4_d1", (dlog_d.size() > 2) ? dlog_d[1] : 24'hxxxxxx, 24'hA5A5A5);
        chk("t4_pc2", (dlog_pc.size() > 2) ? dlog_pc[2] : 24'hxxxxxx, 24'h000000);
        chk("t4_d2", (dlog_d.size() > 2) ? dlog_d[2] : 24'hxxxxxx, 24'h5A5A5A);

        // 5: clock enable toggling, redirect while disabled must be ignored
        reset_dut();
        for (int i = 0; i < 24; i++) begin
            step((i % 2) == 0, (i == 7), 24'h777777, 1'b1);
        end
        chk("t5_count", dlog_pc.size(), 9);
        for (int i = 0; i < dlog_pc.size(); i++) chk_delivery("t5", i, 24'(i));

        // 6: async reset with entries buffered, then a response with nothing outstanding
        reset_dut();
        run(5, 1'b0);
        chk("t6_valid_before", instr_valid, 1);
        rst_req = 1;
        step(1'b1, 1'b0, 24'h0, 1'b0);
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_rd", mem_rd, 0);
        rst_req = 0;
        clear_logs();
        run(9, 1'b0);
        chk("t6_refetch_n", iss_log.size(), 4);
        if (iss_log.size() > 0) chk("t6_refetch_addr", iss_log[0], 24'h0);
        chk("t6_err_before", err, 0);
        spurious = 1;
        run(2, 1'b0);
        chk("t6_err_set", err, 1);
        run(3, 1'b1);
        chk("t6_err_sticky", err, 1);
        rst_req = 1;
        step(1'b1, 1'b0, 24'h0, 1'b0);
        chk("t6_err_cleared", err, 0);
        rst_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
